// File: rtl/grid_map_arbiter.sv
// Two-port read arbiter in front of the single-port grid BRAM, with a tag pipeline for returns.
// Define ARB_ROUND_ROBIN_EN for alternating priority instead of ray priority plus ctl starvation guard.
module grid_map_arbiter #(
    parameter int unsigned N          = 24,
    parameter int unsigned ADDR_W     = $clog2(N * N),
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              ray_req_in,
    input  logic [ADDR_W-1:0] ray_addr_in,
    output logic              ray_gnt_out,
    output logic [DATA_W-1:0] ray_data_out,
    output logic              ray_valid_out,
    input  logic              ctl_req_in,
    input  logic [ADDR_W-1:0] ctl_addr_in,
    output logic              ctl_gnt_out,
    output logic [DATA_W-1:0] ctl_data_out,
    output logic              ctl_valid_out,
    output logic [ADDR_W-1:0] map_addr_out,
    input  logic [DATA_W-1:0] map_data_in,
    output logic              busy_out
);
    localparam int unsigned DEPTH = 1 + RD_LATENCY;
    localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(N * N);

    logic              ctl_prio;
    logic              any_gnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_oob;
    logic [DEPTH-1:0]  tag_valid;
    logic [DEPTH-1:0]  tag_port;   // 0 = ray, 1 = ctl
    logic [DEPTH-1:0]  tag_oob;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] ray_data_q;
    logic [DATA_W-1:0] ctl_data_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    assign ctl_prio = rr_ptr;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr <= 1'b0;
        end else if (ray_req_in && ctl_req_in) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`else
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign ctl_prio = (wait_cnt == WAIT_MAX);

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wait_cnt <= '0;
        end else if (ctl_req_in && !ctl_gnt_out) begin
            if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    // Grants are suppressed while reset is held so all outputs read 0.
    always_comb begin
        ray_gnt_out = rst_in & ray_req_in & ~(ctl_req_in & ctl_prio);
        ctl_gnt_out = rst_in & ctl_req_in & (~ray_req_in | ctl_prio);
        any_gnt     = ray_gnt_out | ctl_gnt_out;
        gnt_addr    = ctl_gnt_out ? ctl_addr_in : ray_addr_in;
        gnt_oob     = ({1'b0, gnt_addr} >= CELLS);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tag_valid    <= '0;
            tag_port     <= '0;
            tag_oob      <= '0;
            map_addr_out <= '0;
            ray_data_q   <= '0;
            ctl_data_q   <= '0;
        end else begin
            tag_valid <= {tag_valid[DEPTH-2:0], any_gnt};
            tag_port  <= {tag_port[DEPTH-2:0], ctl_gnt_out};
            tag_oob   <= {tag_oob[DEPTH-2:0], gnt_oob};
            if (any_gnt && !gnt_oob) begin
                map_addr_out <= gnt_addr;
            end
            if (ray_valid_out) begin
                ray_data_q <= resp_data;
            end
            if (ctl_valid_out) begin
                ctl_data_q <= resp_data;
            end
        end
    end

    // Out-of-range reads return a wall so the collision checker blocks the move.
    always_comb begin
        resp_data     = tag_oob[DEPTH-1] ? DATA_W'(1) : map_data_in;
        ray_valid_out = tag_valid[DEPTH-1] & ~tag_port[DEPTH-1];
        ctl_valid_out = tag_valid[DEPTH-1] & tag_port[DEPTH-1];
        ray_data_out  = ray_valid_out ? resp_data : ray_data_q;
        ctl_data_out  = ctl_valid_out ? resp_data : ctl_data_q;
        busy_out      = |tag_valid;
    end
endmodule

// File: tb/tb_grid_map_arbiter.sv
// Scoreboard bench for grid_map_arbiter: directed requests, expected responses queued at grant,
// popped and compared by a monitor whenever a valid pulse appears.
module tb_grid_map_arbiter;
    localparam int unsigned N  = 24;
    localparam int unsigned AW = $clog2(N * N);
    localparam int unsigned DW = 4;

    typedef struct packed {
        logic        port;
        logic [3:0]  data;
        logic [31:0] cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ray_req, ctl_req;
    logic [AW-1:0] ray_addr, ctl_addr;
    logic          ray_gnt, ctl_gnt, ray_valid, ctl_valid, busy;
    logic [DW-1:0] ray_data, ctl_data, map_data;
    logic [AW-1:0] map_addr;
    logic [DW-1:0] bram_s1;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;
    int unsigned cyc       = 0;
    exp_t        sb[$];

    grid_map_arbiter dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_n),
        .ray_req_in   (ray_req),
        .ray_addr_in  (ray_addr),
        .ray_gnt_out  (ray_gnt),
        .ray_data_out (ray_data),
        .ray_valid_out(ray_valid),
        .ctl_req_in   (ctl_req),
        .ctl_addr_in  (ctl_addr),
        .ctl_gnt_out  (ctl_gnt),
        .ctl_data_out (ctl_data),
        .ctl_valid_out(ctl_valid),
        .map_addr_out (map_addr),
        .map_data_in  (map_data),
        .busy_out     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // "onlywall" map: border cells are walls (1), interior is empty (0).
    function automatic logic [DW-1:0] cell_val(input logic [AW-1:0] a);
        int unsigned r, c;
        r = a / N;
        c = a % N;
        return (r == 0 || r == N - 1 || c == 0 || c == N - 1) ? 4'd1 : 4'd0;
    endfunction

    // Two-stage BRAM read model.
    always @(posedge clk) begin
        bram_s1  <= cell_val(map_addr);
        map_data <= bram_s1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ray_valid && ctl_valid) begin
            check("both_valid", 1, 0);
        end else if (ray_valid || ctl_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'd0, ctl_valid}, 32'hffff_ffff);
            end else begin
                e = sb.pop_front();
                check("resp_port", {31'd0, ctl_valid}, {31'd0, e.port});
                check("resp_data", {28'd0, (ctl_valid ? ctl_data : ray_data)}, {28'd0, e.data});
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // Caller starts just after a posedge; returns just after the negedge of grant+1.
    task automatic single_req(input logic port, input logic [AW-1:0] addr, input logic [3:0] exp_d,
                              input bit push);
        logic [AW-1:0] prev;
        bit            got;
        int            n;
        exp_t          e;
        prev = map_addr;
        got  = 0;
        n    = 0;
        if (port) begin ctl_req = 1'b1; ctl_addr = addr; end
        else begin ray_req = 1'b1; ray_addr = addr; end
        while (!got && n < 20) begin
            @(negedge clk);
            if (port ? ctl_gnt : ray_gnt) got = 1;
            else n++;
        end
        if (!got) begin
            check("gnt_timeout", 0, 1);
        end else begin
            check("other_gnt_low", {31'd0, port ? ray_gnt : ctl_gnt}, 0);
            if (push) begin
                e.port = port; e.data = exp_d; e.cyc = cyc + 3;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        ray_req = 1'b0;
        ctl_req = 1'b0;
        @(negedge clk);
        check("map_addr", {22'd0, map_addr}, {22'd0, (addr >= AW'(N * N)) ? prev : addr});
        check("busy_high", {31'd0, busy}, 1);
    endtask

    task automatic drain();
        repeat (5) @(negedge clk);
        check("busy_idle", {31'd0, busy}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        bit   exp_ctl;
        int   n;
        rst_n = 1'b0; ray_req = 1'b0; ctl_req = 1'b0; ray_addr = '0; ctl_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {30'd0, ray_valid, ctl_valid}, 0);
        check("rst_map_addr", {22'd0, map_addr}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        single_req(1'b0, AW'(25), 4'd0, 1);   // interior cell (1,1)
        drain();
        check("ray_data_hold", {28'd0, ray_data}, 0);
        single_req(1'b1, AW'(0), 4'd1, 1);    // corner wall
        drain();
        check("ctl_data_hold", {28'd0, ctl_data}, 1);

        // Both requesting continuously: ray(addr 30 -> 0), ctl(addr 47 -> wall 1).
        ray_req = 1'b1; ray_addr = AW'(30);
        ctl_req = 1'b1; ctl_addr = AW'(47);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            exp_ctl = (i % 2) == 1;
`else
            exp_ctl = (i % 8) == 7;
`endif
            check("arb_ray_gnt", {31'd0, ray_gnt}, {31'd0, !exp_ctl});
            check("arb_ctl_gnt", {31'd0, ctl_gnt}, {31'd0, exp_ctl});
            e.port = exp_ctl; e.data = exp_ctl ? 4'd1 : 4'd0; e.cyc = cyc + 3;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        ray_req = 1'b0; ctl_req = 1'b0;
        drain();

        single_req(1'b1, AW'(600), 4'd1, 1);  // out of range -> forced wall
        drain();

        // Reset two cycles after a grant: that read must never return.
        single_req(1'b0, AW'(26), 4'd0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0; ray_req = 1'b1; ctl_req = 1'b1;
        #1;
        check("rstmid_gnt", {30'd0, ray_gnt, ctl_gnt}, 0);
        check("rstmid_valid", {30'd0, ray_valid, ctl_valid}, 0);
        check("rstmid_map_addr", {22'd0, map_addr}, 0);
        check("rstmid_busy", {31'd0, busy}, 0);
        check("rstmid_ctl_data", {28'd0, ctl_data}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; ray_req = 1'b0; ctl_req = 1'b0;
        @(posedge clk); #1;
        single_req(1'b0, AW'(30), 4'd0, 1);
        drain();

        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
